// File: rtl/i2c_pkg.sv
// ============================================================================
// Module : i2c_pkg
// Shared I2C widths and the slave receiver state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;
    localparam int I2C_CNT_W  = $clog2(I2C_BYTE_W);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_DATA     = 3'd3,
        ST_DATA_ACK = 3'd4,
        ST_IGNORE   = 3'd5
    } i2c_state_e;

endpackage

`default_nettype wire

// File: rtl/i2c_sync_edge.sv
// ============================================================================
// Module : i2c_sync_edge
// Two-flop synchronizer for one bus line plus rise/fall detection.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module i2c_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    // Reset to 1 so an idle (pulled-up) bus produces no spurious edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_meta   <= din;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign sync = r_sync;
    assign rise = r_sync & ~r_sync_d;
    assign fall = ~r_sync & r_sync_d;

endmodule

`default_nettype wire

// File: rtl/i2c_slave_rx.sv
// ============================================================================
// Module : i2c_slave_rx
// Write-only I2C slave: receives bytes addressed to SLAVE_ADDR onto a
// valid/ready holding register, ACKing only bytes it can keep.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h1A
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_first,
    output logic                  busy
);

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;

    i2c_sync_edge u_scl_sync (
        .clk  (sys_clk),
        .rst  (rst),
        .din  (scl_in),
        .sync (w_scl),
        .rise (w_scl_rise),
        .fall (w_scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk  (sys_clk),
        .rst  (rst),
        .din  (sda_in),
        .sync (w_sda),
        .rise (w_sda_rise),
        .fall (w_sda_fall)
    );

    i2c_state_e            r_state,    w_state_nxt;
    logic [I2C_CNT_W-1:0]  r_bit_cnt,  w_bit_cnt_nxt;
    logic [I2C_BYTE_W-1:0] r_shift,    w_shift_nxt;
    logic [I2C_BYTE_W-1:0] r_rx_data,  w_rx_data_nxt;
    logic                  r_rx_valid, w_rx_valid_nxt;
    logic                  r_rx_first, w_rx_first_nxt;
    logic                  r_first_pend, w_first_pend_nxt;
    logic                  r_sda_oe,   w_sda_oe_nxt;
    logic                  r_busy,     w_busy_nxt;

    logic                  w_start;
    logic                  w_stop;
    logic                  w_byte_done;
    logic [I2C_BYTE_W-1:0] w_shift_in;

    assign w_start     = w_sda_fall & w_scl;
    assign w_stop      = w_sda_rise & w_scl;
    assign w_shift_in  = {r_shift[I2C_BYTE_W-2:0], w_sda};
    assign w_byte_done = w_scl_rise && (r_bit_cnt == I2C_CNT_W'(I2C_BYTE_W - 1));

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_first   <= 1'b0;
            r_first_pend <= 1'b0;
            r_sda_oe     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_rx_data    <= w_rx_data_nxt;
            r_rx_valid   <= w_rx_valid_nxt;
            r_rx_first   <= w_rx_first_nxt;
            r_first_pend <= w_first_pend_nxt;
            r_sda_oe     <= w_sda_oe_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_shift_nxt      = r_shift;
        w_rx_data_nxt    = r_rx_data;
        w_rx_valid_nxt   = r_rx_valid;
        w_rx_first_nxt   = r_rx_first;
        w_first_pend_nxt = r_first_pend;
        w_sda_oe_nxt     = r_sda_oe;
        w_busy_nxt       = r_busy;

        if (r_rx_valid && rx_ready) begin
            w_rx_valid_nxt = 1'b0;
        end

        if (w_start) begin
            w_state_nxt   = ST_ADDR;
            w_bit_cnt_nxt = '0;
            w_shift_nxt   = '0;
            w_sda_oe_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
        end else if (w_stop) begin
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = '0;
            w_sda_oe_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_shift_in;
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                    if (w_byte_done) begin
                        if (w_shift_in[I2C_BYTE_W-1:1] == SLAVE_ADDR && !w_shift_in[0]) begin
                            w_state_nxt      = ST_ADDR_ACK;
                            w_first_pend_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_IGNORE;
                        end
                    end
                end
                // The oe register doubles as the ACK phase: first SCL fall
                // starts driving, second fall releases and resumes receiving.
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_sda_oe_nxt = 1'b1;
                            w_busy_nxt   = 1'b1;
                        end else begin
                            w_sda_oe_nxt  = 1'b0;
                            w_state_nxt   = ST_DATA;
                            w_bit_cnt_nxt = '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_shift_in;
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                    if (w_byte_done) begin
                        if (!r_rx_valid || rx_ready) begin
                            w_rx_data_nxt    = w_shift_in;
                            w_rx_valid_nxt   = 1'b1;
                            w_rx_first_nxt   = r_first_pend;
                            w_first_pend_nxt = 1'b0;
                            w_state_nxt      = ST_DATA_ACK;
                        end else begin
                            w_state_nxt = ST_IGNORE;
                        end
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                    w_sda_oe_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe   = r_sda_oe;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign rx_first = r_rx_first;
    assign busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_rx.sv
// ============================================================================
// Module : tb_i2c_slave_rx
// Directed I2C master stimulus with a scoreboard monitor on the byte output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_i2c_slave_rx;
    import i2c_pkg::*;

    localparam int Q = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
    } exp_t;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_first;
    logic       busy;

    wire scl_in = scl_m;
    wire sda_in = sda_m & ~sda_oe;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    int   rise_cyc   = 0;
    logic prev_valid = 1'b0;

    i2c_slave_rx #(.SLAVE_ADDR(7'h1A)) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_first (rx_first),
        .busy     (busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: compares each handshaked byte against the queue
    always @(negedge sys_clk) begin
        if (!rst) begin
            if (rx_valid && !prev_valid) begin
                check("rx_valid_latency", cyc - rise_cyc, 3);
            end
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h expected none", rx_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rx_data", int'(rx_data), int'(e.data));
                    check("rx_first", int'(rx_first), int'(e.first));
                end
            end
        end
        prev_valid <= rx_valid;
    end

    task automatic wq();
        repeat (Q) @(negedge sys_clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; wq();
        rise_cyc = cyc;
        scl_m = 1'b1; wq(); wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b);
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        ack = ~sda_in;
        wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic push(input logic [7:0] d, input logic f);
        exp_t e;
        e.data  = d;
        e.first = f;
        exp_q.push_back(e);
    endtask

    initial begin
        logic ack;
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rx_ready = 1'b1;
        repeat (4) @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);
        check("reset_sda_oe", int'(sda_oe), 0);
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_rx_first", int'(rx_first), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_state", int'(dut.r_state), int'(ST_IDLE));

        // Addressed write of one byte
        i2c_start();
        send_byte(8'h34, ack);
        check("t1_addr_ack", int'(ack), 1);
        check("t1_busy", int'(busy), 1);
        push(8'hA5, 1'b1);
        send_byte(8'hA5, ack);
        check("t1_data_ack", int'(ack), 1);
        i2c_stop();
        check("t1_busy_after_stop", int'(busy), 0);
        check("t1_rx_data_kept", int'(rx_data), 8'hA5);
        check("t1_rx_first_kept", int'(rx_first), 1);

        // Wrong address
        i2c_start();
        send_byte(8'h36, ack);
        check("t2_addr_nack", int'(ack), 0);
        check("t2_busy", int'(busy), 0);
        send_byte(8'h55, ack);
        check("t2_data_nack", int'(ack), 0);
        check("t2_rx_valid", int'(rx_valid), 0);
        i2c_stop();

        // Read request is not served
        i2c_start();
        send_byte(8'h35, ack);
        check("t3_addr_nack", int'(ack), 0);
        check("t3_state_ignore", int'(dut.r_state), int'(ST_IGNORE));
        send_byte(8'h77, ack);
        check("t3_state_still_ignore", int'(dut.r_state), int'(ST_IGNORE));
        i2c_stop();
        check("t3_state_idle", int'(dut.r_state), int'(ST_IDLE));

        // Backpressure: second byte arrives while the first is held
        rx_ready = 1'b0;
        i2c_start();
        send_byte(8'h34, ack);
        check("t4_addr_ack", int'(ack), 1);
        push(8'h11, 1'b1);
        send_byte(8'h11, ack);
        check("t4_first_ack", int'(ack), 1);
        send_byte(8'h22, ack);
        check("t4_second_nack", int'(ack), 0);
        check("t4_state_ignore", int'(dut.r_state), int'(ST_IGNORE));
        i2c_stop();
        check("t4_rx_valid_held", int'(rx_valid), 1);
        check("t4_rx_data_held", int'(rx_data), 8'h11);
        rx_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge sys_clk);
        check("t4_drained", exp_q.size(), 0);
        @(negedge sys_clk);
        check("t4_rx_valid_cleared", int'(rx_valid), 0);

        // Repeated START mid-byte
        i2c_start();
        send_byte(8'h34, ack);
        check("t5_addr_ack", int'(ack), 1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_start();
        check("t5_rs_state", int'(dut.r_state), int'(ST_ADDR));
        check("t5_rs_busy", int'(busy), 0);
        send_byte(8'h34, ack);
        check("t5_readdr_ack", int'(ack), 1);
        push(8'h5A, 1'b1);
        send_byte(8'h5A, ack);
        check("t5_data_ack", int'(ack), 1);
        push(8'hC3, 1'b0);
        send_byte(8'hC3, ack);
        check("t5_data2_ack", int'(ack), 1);
        i2c_stop();

        // Reset during the address ACK
        i2c_start();
        send_bits(8'h34);
        sda_m = 1'b1; wq();
        check("t6_pre_state", int'(dut.r_state), int'(ST_ADDR_ACK));
        check("t6_pre_sda_oe", int'(sda_oe), 1);
        rst = 1'b1;
        @(posedge sys_clk); #1;
        check("t6_sda_oe", int'(sda_oe), 0);
        check("t6_state", int'(dut.r_state), int'(ST_IDLE));
        check("t6_busy", int'(busy), 0);
        check("t6_rx_valid", int'(rx_valid), 0);
        check("t6_rx_first", int'(rx_first), 0);
        check("t6_rx_data", int'(rx_data), 0);
        @(negedge sys_clk);
        rst = 1'b0;
        wq();
        scl_m = 1'b1; wq();
        scl_m = 1'b0; wq();
        check("t6_stay_idle", int'(dut.r_state), int'(ST_IDLE));
        check("t6_stay_released", int'(sda_oe), 0);
        i2c_start();
        send_byte(8'h34, ack);
        check("t6_recover_ack", int'(ack), 1);
        push(8'h99, 1'b1);
        send_byte(8'h99, ack);
        i2c_stop();
        repeat (10) @(negedge sys_clk);
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
